// File: rtl/cisc_pkg.sv
// Shared opcode, state and instruction-field definitions for the mini-CISC sequencer.
package cisc_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_MOV  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_NOT  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_IMM    = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;

  typedef struct packed {
    logic is_alu;
    logic is_ldi;
    logic is_halt;
    logic is_illegal;
  } dec_t;

  function automatic logic [3:0] fld_op(input logic [7:0] b);
    return b[7:4];
  endfunction

  function automatic logic [1:0] fld_rd(input logic [7:0] b);
    return b[3:2];
  endfunction

  function automatic logic [1:0] fld_rs(input logic [7:0] b);
    return b[1:0];
  endfunction

endpackage

// File: rtl/seq_decode.sv
// Opcode class decode; purely combinational, zero latency, no flow control.
module seq_decode
  import cisc_pkg::*;
(
  input  logic [3:0] opcode,
  output dec_t       dec
);

  always_comb begin
    dec = '0;
    case (opcode)
      OP_NOP:  dec = '0;
      OP_LDI:  dec.is_ldi = 1'b1;
      OP_MOV, OP_ADD, OP_SUB, OP_AND,
      OP_OR,  OP_XOR, OP_NOT:
               dec.is_alu = 1'b1;
      OP_HALT: dec.is_halt = 1'b1;
      default: dec.is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/reg_bank_seq.sv
// Instruction sequencer for the 4x8 bank and ALU; ALU op write-back 3+k cycles after accept.
// instr_ready is low outside IDLE/IMM, so bytes offered while busy stay on the bus unconsumed.
module reg_bank_seq
  import cisc_pkg::*;
#(
  parameter int ALU_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  input  logic [7:0] instr_data,
  output logic       instr_ready,
  output logic [3:0] load_en,
  output logic [7:0] load_data,
  output logic [3:0] alu_op,
  output logic [1:0] alu_a_sel,
  output logic [1:0] alu_b_sel,
  output logic       alu_start,
  input  logic       alu_done,
  output logic       wr_en,
  output logic [1:0] wr_sel,
  output logic       halted,
  output logic       err
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(ALU_TIMEOUT - 1);

  logic [2:0]       state;
  logic [2:0]       nxt;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       dec_op;
  dec_t             dec;
  logic             xfer;
  logic             timeout;

  // In IDLE the byte on the bus is classified so err can fire in the DECODE cycle;
  // afterwards the latched opcode drives the same decoder.
  assign dec_op = (state == ST_IDLE) ? fld_op(instr_data) : alu_op;

  seq_decode u_decode (
    .opcode (dec_op),
    .dec    (dec)
  );

  assign xfer    = instr_valid & instr_ready;
  assign timeout = (ALU_TIMEOUT != 0) && (cnt == TO_LAST) && !alu_done;

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:   if (xfer) nxt = ST_DECODE;
      ST_DECODE: begin
        if (dec.is_ldi)       nxt = ST_IMM;
        else if (dec.is_alu)  nxt = ST_EXEC;
        else if (dec.is_halt) nxt = ST_HALT;
        else                  nxt = ST_IDLE;
      end
      ST_IMM:    if (xfer) nxt = ST_IDLE;
      ST_EXEC: begin
        if (alu_done)     nxt = ST_WB;
        else if (timeout) nxt = ST_IDLE;
      end
      ST_WB:     nxt = ST_IDLE;
      ST_HALT:   nxt = ST_HALT;
      default:   nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      instr_ready <= 1'b1;
      load_en     <= '0;
      load_data   <= '0;
      alu_op      <= '0;
      alu_a_sel   <= '0;
      alu_b_sel   <= '0;
      alu_start   <= 1'b0;
      wr_en       <= 1'b0;
      wr_sel      <= '0;
      halted      <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= nxt;
      instr_ready <= (nxt == ST_IDLE) || (nxt == ST_IMM);
      halted      <= (nxt == ST_HALT);
      alu_start   <= (state == ST_DECODE) && (nxt == ST_EXEC);
      cnt         <= (state == ST_EXEC) ? cnt + 1'b1 : '0;
      load_en     <= '0;
      wr_en       <= 1'b0;
      wr_sel      <= '0;
      err         <= 1'b0;

      if (state == ST_IDLE && xfer) begin
        alu_op    <= fld_op(instr_data);
        alu_a_sel <= fld_rd(instr_data);
        alu_b_sel <= fld_rs(instr_data);
        err       <= dec.is_illegal;
      end

      if (state == ST_IMM && xfer) begin
        load_data <= instr_data;
        load_en   <= 4'b0001 << alu_a_sel;
      end

      if (state == ST_EXEC) begin
        if (alu_done) begin
          wr_en  <= 1'b1;
          wr_sel <= alu_a_sel;
        end else if (timeout) begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_bank_seq.sv
// Directed vector table, hand sequences and a randomized schedule for reg_bank_seq.
module tb_reg_bank_seq;

  logic       clk;
  logic       rst;
  logic       instr_valid;
  logic [7:0] instr_data;
  logic       instr_ready;
  logic [3:0] load_en;
  logic [7:0] load_data;
  logic [3:0] alu_op;
  logic [1:0] alu_a_sel;
  logic [1:0] alu_b_sel;
  logic       alu_start;
  logic       alu_done;
  logic       wr_en;
  logic [1:0] wr_sel;
  logic       halted;
  logic       err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  reg_bank_seq #(.ALU_TIMEOUT(16), .CNT_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_data  (instr_data),
    .instr_ready (instr_ready),
    .load_en     (load_en),
    .load_data   (load_data),
    .alu_op      (alu_op),
    .alu_a_sel   (alu_a_sel),
    .alu_b_sel   (alu_b_sel),
    .alu_start   (alu_start),
    .alu_done    (alu_done),
    .wr_en       (wr_en),
    .wr_sel      (wr_sel),
    .halted      (halted),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp_v);
    end
  endtask

  // One row = outputs expected at this cycle, then the inputs driven for it.
  typedef struct {
    bit       rst;
    bit       vld;
    bit [7:0] dat;
    bit       done;
    bit       rdy;
    bit [3:0] ld;
    bit [7:0] ldd;
    bit       st;
    bit       wr;
    bit [1:0] ws;
    bit       er;
    bit       hl;
    bit       fchk;
    bit [7:0] fld;
  } vec_t;

  function automatic vec_t mk(bit r, bit vl, bit [7:0] d, bit dn, bit rdy, bit [3:0] ld,
                              bit [7:0] ldd, bit st, bit wr, bit [1:0] ws, bit er, bit hl,
                              bit fc, bit [7:0] fld);
    vec_t x;
    x.rst = r; x.vld = vl; x.dat = d; x.done = dn; x.rdy = rdy; x.ld = ld; x.ldd = ldd;
    x.st = st; x.wr = wr; x.ws = ws; x.er = er; x.hl = hl; x.fchk = fc; x.fld = fld;
    return x;
  endfunction

  // Randomized schedule, built from the documented per-opcode latencies.
  localparam int NC = 4000;
  bit       d_valid [NC];
  bit [7:0] d_data  [NC];
  bit       d_done  [NC];
  bit       busy    [NC];
  bit       e_ready [NC];
  bit [3:0] e_ld    [NC];
  bit [7:0] e_ldd   [NC];
  bit       e_start [NC];
  bit       e_wr    [NC];
  bit [1:0] e_ws    [NC];
  bit       e_err   [NC];
  bit       e_fchk  [NC];
  bit [7:0] e_fld   [NC];
  int       ncy;

  task automatic build();
    int free, busfree, v, a, v2, a2, k, kind;
    bit [7:0] b, imm;
    free = 0;
    busfree = 0;
    for (int c = 0; c < NC; c++) d_data[c] = 8'($urandom);
    while (free < NC - 60) begin
      v = free - int'($urandom_range(0, 2)) + int'($urandom_range(0, 2));
      if (v < busfree) v = busfree;
      a = (v > free) ? v : free;
      for (int c = free; c <= a; c++) e_ready[c] = 1'b1;
      kind = int'($urandom_range(0, 9));
      b = 8'($urandom);
      case (kind)
        0:       b[7:4] = 4'h0;
        1:       b[7:4] = 4'(9 + $urandom_range(0, 5));
        2, 3:    b[7:4] = 4'h1;
        default: b[7:4] = 4'(2 + $urandom_range(0, 6));
      endcase
      for (int c = v; c <= a; c++) begin
        d_valid[c] = 1'b1;
        d_data[c]  = b;
      end
      if (kind == 0) begin
        free = a + 2; busfree = a + 1;
      end else if (kind == 1) begin
        e_err[a+1] = 1'b1;
        free = a + 2; busfree = a + 1;
      end else if (kind <= 3) begin
        imm = 8'($urandom);
        v2  = a + 1 + int'($urandom_range(0, 2));
        a2  = (v2 > a + 2) ? v2 : a + 2;
        for (int c = a + 2; c <= a2; c++) e_ready[c] = 1'b1;
        for (int c = v2; c <= a2; c++) begin
          d_valid[c] = 1'b1;
          d_data[c]  = imm;
        end
        e_ld[a2+1]  = 4'b0001 << b[3:2];
        e_ldd[a2+1] = imm;
        free = a2 + 1; busfree = a2 + 1;
      end else begin
        e_start[a+2] = 1'b1;
        busfree = a + 1;
        if ($urandom_range(0, 7) == 0) begin
          for (int c = a + 2; c <= a + 17; c++) busy[c] = 1'b1;
          for (int c = a + 1; c <= a + 17; c++) begin e_fchk[c] = 1'b1; e_fld[c] = b; end
          e_err[a+18] = 1'b1;
          free = a + 18;
        end else begin
          k = ($urandom_range(0, 5) == 0) ? 15 : int'($urandom_range(0, 6));
          for (int c = a + 2; c <= a + 2 + k; c++) busy[c] = 1'b1;
          for (int c = a + 1; c <= a + 3 + k; c++) begin e_fchk[c] = 1'b1; e_fld[c] = b; end
          d_done[a+2+k] = 1'b1;
          e_wr[a+3+k]   = 1'b1;
          e_ws[a+3+k]   = b[3:2];
          free = a + 4 + k;
        end
      end
    end
    ncy = free + 3;
    for (int c = free; c < ncy; c++) e_ready[c] = 1'b1;
    // Stray alu_done anywhere outside EXEC must be ignored.
    for (int c = 0; c < ncy; c++)
      if (!busy[c] && !d_done[c]) d_done[c] = ($urandom_range(0, 3) == 0);
  endtask

  vec_t tbl [26];

  initial begin
    // LDI r2,0x5A with the immediate offered early during DECODE
    tbl[0]  = mk(0,1,8'h18,0, 1,4'h0,8'h00, 0,0,2'd0,0,0, 0,8'h00);
    tbl[1]  = mk(0,1,8'h5A,0, 0,4'h0,8'h00, 0,0,2'd0,0,0, 0,8'h00);
    tbl[2]  = mk(0,1,8'h5A,0, 1,4'h0,8'h00, 0,0,2'd0,0,0, 0,8'h00);
    tbl[3]  = mk(0,0,8'h00,0, 1,4'h4,8'h5A, 0,0,2'd0,0,0, 0,8'h00);
    tbl[4]  = mk(0,0,8'h00,0, 1,4'h0,8'h00, 0,0,2'd0,0,0, 0,8'h00);
    // ADD r1,r2 with alu_done three cycles after alu_start
    tbl[5]  = mk(0,1,8'h36,0, 1,4'h0,8'h00, 0,0,2'd0,0,0, 0,8'h00);
    tbl[6]  = mk(0,0,8'h00,0, 0,4'h0,8'h00, 0,0,2'd0,0,0, 1,8'h36);
    tbl[7]  = mk(0,0,8'h00,0, 0,4'h0,8'h00, 1,0,2'd0,0,0, 1,8'h36);
    tbl[8]  = mk(0,0,8'h00,0, 0,4'h0,8'h00, 0,0,2'd0,0,0, 1,8'h36);
    tbl[9]  = mk(0,0,8'h00,0, 0,4'h0,8'h00, 0,0,2'd0,0,0, 1,8'h36);
    tbl[10] = mk(0,0,8'h00,1, 0,4'h0,8'h00, 0,0,2'd0,0,0, 1,8'h36);
    tbl[11] = mk(0,0,8'h00,0, 0,4'h0,8'h00, 0,1,2'd1,0,0, 1,8'h36);
    tbl[12] = mk(0,0,8'h00,0, 1,4'h0,8'h00, 0,0,2'd0,0,0, 0,8'h00);
    // illegal opcode 0xA
    tbl[13] = mk(0,1,8'hA5,0, 1,4'h0,8'h00, 0,0,2'd0,0,0, 0,8'h00);
    tbl[14] = mk(0,0,8'h00,0, 0,4'h0,8'h00, 0,0,2'd0,1,0, 0,8'h00);
    tbl[15] = mk(0,0,8'h00,0, 1,4'h0,8'h00, 0,0,2'd0,0,0, 0,8'h00);
    // NOP with stray alu_done
    tbl[16] = mk(0,1,8'h00,1, 1,4'h0,8'h00, 0,0,2'd0,0,0, 0,8'h00);
    tbl[17] = mk(0,0,8'h00,1, 0,4'h0,8'h00, 0,0,2'd0,0,0, 0,8'h00);
    tbl[18] = mk(0,0,8'h00,0, 1,4'h0,8'h00, 0,0,2'd0,0,0, 0,8'h00);
    // HALT, a byte offered while halted, then reset
    tbl[19] = mk(0,1,8'hF0,0, 1,4'h0,8'h00, 0,0,2'd0,0,0, 0,8'h00);
    tbl[20] = mk(0,0,8'h00,0, 0,4'h0,8'h00, 0,0,2'd0,0,0, 0,8'h00);
    tbl[21] = mk(0,0,8'h00,0, 0,4'h0,8'h00, 0,0,2'd0,0,1, 0,8'h00);
    tbl[22] = mk(0,1,8'h10,0, 0,4'h0,8'h00, 0,0,2'd0,0,1, 0,8'h00);
    tbl[23] = mk(1,0,8'h00,0, 0,4'h0,8'h00, 0,0,2'd0,0,1, 0,8'h00);
    tbl[24] = mk(0,0,8'h00,0, 1,4'h0,8'h00, 0,0,2'd0,0,0, 0,8'h00);
    tbl[25] = mk(0,0,8'h00,0, 1,4'h0,8'h00, 0,0,2'd0,0,0, 0,8'h00);

    rst = 1'b1; instr_valid = 1'b0; instr_data = 8'h00; alu_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_ready", instr_ready, 1);
    chk("reset_outs", {load_en, load_data, alu_op, alu_a_sel, alu_b_sel, alu_start,
                       wr_en, wr_sel, halted, err}, 0);

    for (int i = 0; i < 26; i++) begin
      @(negedge clk); cyc++;
      chk("t_ready",  instr_ready, tbl[i].rdy);
      chk("t_ld_en",  load_en,     tbl[i].ld);
      chk("t_start",  alu_start,   tbl[i].st);
      chk("t_wr_en",  wr_en,       tbl[i].wr);
      chk("t_err",    err,         tbl[i].er);
      chk("t_halted", halted,      tbl[i].hl);
      if (tbl[i].ld != 0) chk("t_ld_data", load_data, tbl[i].ldd);
      if (tbl[i].wr)      chk("t_wr_sel",  wr_sel,    tbl[i].ws);
      if (tbl[i].fchk) begin
        chk("t_alu_op", alu_op,    tbl[i].fld[7:4]);
        chk("t_a_sel",  alu_a_sel, tbl[i].fld[3:2]);
        chk("t_b_sel",  alu_b_sel, tbl[i].fld[1:0]);
      end
      if (i == 24) chk("t_rst_outs", {load_data, alu_op, alu_a_sel, alu_b_sel, wr_sel}, 0);
      rst = tbl[i].rst; instr_valid = tbl[i].vld; instr_data = tbl[i].dat; alu_done = tbl[i].done;
    end

    // SUB r2,r1 with alu_done never returned: err at start+16, no write-back
    for (int i = 0; i < 21; i++) begin
      @(negedge clk); cyc++;
      chk("to_err",   err,         (i == 18) ? 1 : 0);
      chk("to_wr",    wr_en,       0);
      chk("to_ready", instr_ready, (i == 0 || i >= 18) ? 1 : 0);
      if (i == 2) chk("to_start", alu_start, 1);
      instr_valid = (i == 0); instr_data = 8'h49; alu_done = 1'b0;
    end

    // XOR r3,r1 aborted by reset in EXEC; a late alu_done must not write back
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); cyc++;
      if (i == 2) chk("rx_start", alu_start, 1);
      if (i >= 5) begin
        chk("rx_ready", instr_ready, 1);
        chk("rx_wr",    wr_en,       0);
        chk("rx_err",   err,         0);
        chk("rx_start_lo", alu_start, 0);
      end
      instr_valid = (i == 0); instr_data = 8'h7D;
      rst = (i == 4);
      alu_done = (i == 6 || i == 7);
    end

    build();
    @(negedge clk); rst = 1'b1; instr_valid = 1'b0; alu_done = 1'b0;
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < ncy; c++) begin
      @(negedge clk); cyc++;
      chk("r_ready",  instr_ready, e_ready[c]);
      chk("r_ld_en",  load_en,     e_ld[c]);
      chk("r_start",  alu_start,   e_start[c]);
      chk("r_wr_en",  wr_en,       e_wr[c]);
      chk("r_err",    err,         e_err[c]);
      chk("r_halted", halted,      0);
      if (e_ld[c] != 0) chk("r_ld_data", load_data, e_ldd[c]);
      if (e_wr[c])      chk("r_wr_sel",  wr_sel,    e_ws[c]);
      if (e_fchk[c]) begin
        chk("r_alu_op", alu_op,    e_fld[c][7:4]);
        chk("r_a_sel",  alu_a_sel, e_fld[c][3:2]);
        chk("r_b_sel",  alu_b_sel, e_fld[c][1:0]);
      end
      instr_valid = d_valid[c]; instr_data = d_data[c]; alu_done = d_done[c];
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
